imem_boot: RTL and testbench

Parametrised, loadable instruction memory for the single-cycle/pipelined MIPS core. It replaces a fixed, reset-initialised program store. After reset, a program is streamed in word by word over a load port; the block then serves registered instruction fetches. Fetches that are misaligned or fall beyond the loaded program return a NOP and raise a fault flag. It sits between the boot source (testbench or host) and the core's fetch stage.

---
 rtl/imem_boot.sv | 111 +++++++++++
 tb/tb_imem_boot.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot.sv
// Loadable instruction memory for the MIPS core.
// After reset a program is streamed in over the load port. Once the last word
// is written (or the array is full), the block serves registered fetches.
// A fetch that is misaligned or beyond the loaded program returns NOP_WORD
// and raises fault.
//
// state | meaning
// ------+-------------------------------------------------------------
// LOAD  | accepting program words; fetches ignored (reset state)
// RUN   | memory read-only; fetches served; left only through reset
module imem_boot #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = '0,
  localparam int               IDX_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic [IDX_W:0]    words_loaded,
  input  logic              fetch_req,
  input  logic [31:0]       pc,
  input  logic              hold,
  output logic [DATA_W-1:0] ins,
  output logic              ins_valid,
  output logic              fault
);

  typedef enum logic {LOAD, RUN} state_t;

  state_t            state, state_nxt;
  logic [IDX_W:0]    cnt_nxt;
  logic              wr_en;
  logic              accept;
  logic              fetch_fault;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [29:0]       word_addr;
  logic [DATA_W-1:0] mem [DEPTH];

  assign load_ready = (state == LOAD);

  // While loading, the stored-word count doubles as the write pointer.
  assign wr_idx    = words_loaded[IDX_W-1:0];
  assign word_addr = pc[31:2];
  assign rd_idx    = pc[IDX_W+1:2];

  // The range check uses the whole word address, so pcs that alias into
  // the array above DEPTH still fault.
  assign fetch_fault = (pc[1:0] != 2'b00) || (word_addr >= 30'(words_loaded));

  // Next-state, load write enable, word count and fetch acceptance.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = words_loaded;
    wr_en     = 1'b0;
    accept    = 1'b0;
    case (state)
      LOAD: begin
        if (load_valid) begin
          wr_en = 1'b1;
          if (words_loaded != (IDX_W+1)'(DEPTH))
            cnt_nxt = words_loaded + 1'b1;
          if (load_last || (wr_idx == IDX_W'(DEPTH - 1)))
            state_nxt = RUN;
        end
      end
      RUN: begin
        accept = fetch_req && !hold;
      end
    endcase
  end

  // State and word-count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= LOAD;
      words_loaded <= '0;
    end else begin
      state        <= state_nxt;
      words_loaded <= cnt_nxt;
    end
  end

  // Program storage; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_idx] <= load_data;
  end

  // Registered fetch result; hold freezes all three outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ins       <= NOP_WORD;
      ins_valid <= 1'b0;
      fault     <= 1'b0;
    end else if (!hold) begin
      if (accept) begin
        ins       <= fetch_fault ? NOP_WORD : mem[rd_idx];
        fault     <= fetch_fault;
        ins_valid <= 1'b1;
      end else begin
        ins_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot.sv
// Self-checking bench for imem_boot: directed scenarios plus randomized
// load/fetch rounds checked against a queue-based program model.
module tb_imem_boot;

  localparam int          DEPTH = 16;
  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic             clk;
  logic             rst;
  logic             load_valid;
  logic [31:0]      load_data;
  logic             load_last;
  logic             load_ready;
  logic [IDX_W:0]   words_loaded;
  logic             fetch_req;
  logic [31:0]      pc;
  logic             hold;
  logic [31:0]      ins;
  logic             ins_valid;
  logic             fault;

  int n_cmp = 0;
  int n_err = 0;

  // model: program as a queue, plus the expected output registers
  logic [31:0] prog [$];
  bit          m_run;
  logic [31:0] m_ins;
  bit          m_valid;
  bit          m_fault;

  imem_boot #(.DATA_W(32), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .words_loaded(words_loaded),
    .fetch_req(fetch_req), .pc(pc), .hold(hold),
    .ins(ins), .ins_valid(ins_valid), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check_val("load_ready", 32'(load_ready), 32'(!m_run));
    check_val("words_loaded", 32'(words_loaded), 32'(prog.size()));
    check_val("ins_valid", 32'(ins_valid), 32'(m_valid));
    check_val("ins", ins, m_ins);
    check_val("fault", 32'(fault), 32'(m_fault));
  endtask

  task automatic do_reset();
    load_valid = 1'b0;
    load_last  = 1'b0;
    fetch_req  = 1'b0;
    hold       = 1'b0;
    rst        = 1'b0;
    #1;
    prog.delete();
    m_run   = 1'b0;
    m_ins   = NOP;
    m_valid = 1'b0;
    m_fault = 1'b0;
    check_all();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare.
  task automatic step(input bit lv, input logic [31:0] ld, input bit ll,
                      input bit fr, input logic [31:0] p, input bit h);
    bit          was_run;
    logic [31:0] idx;
    load_valid = lv;
    load_data  = ld;
    load_last  = ll;
    fetch_req  = fr;
    pc         = p;
    hold       = h;
    @(posedge clk);
    #1;
    was_run = m_run;
    if (!m_run && lv) begin
      if (prog.size() < DEPTH) prog.push_back(ld);
      if (ll || prog.size() == DEPTH) m_run = 1'b1;
    end
    if (!h) begin
      if (was_run && fr) begin
        idx     = p >> 2;
        m_fault = (p % 4 != 0) || (idx >= prog.size());
        m_ins   = m_fault ? NOP : prog[idx];
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    check_all();
  endtask

  task automatic fetch(input logic [31:0] p);
    step(1'b0, 32'h0, 1'b0, 1'b1, p, 1'b0);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    int n;
    n = (prog.size() > 0) ? prog.size() : 1;
    case ($urandom_range(0, 3))
      0: p = 32'($urandom_range(0, n - 1)) << 2;
      1: p = 32'($urandom_range(0, 2 * DEPTH - 1)) << 2;
      2: p = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      default: p = $urandom;
    endcase
    return p;
  endfunction

  initial begin
    logic [31:0] w [3];
    w[0] = 32'h0085_1020;
    w[1] = 32'h2040_0004;
    w[2] = 32'h0045_6024;
    rst = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    fetch_req = 1'b0; pc = '0; hold = 1'b0;

    // three-word program, fetch_req held high while loading
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, w[i], i == 2, 1'b1, 32'(4 * i), 1'b0);
    check_val("ld3_ready", 32'(load_ready), 32'd0);
    check_val("ld3_count", 32'(words_loaded), 32'd3);
    check_val("ld3_ivalid", 32'(ins_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      fetch(32'(4 * i));
      check_val("f3_ins", ins, w[i]);
      check_val("f3_fault", 32'(fault), 32'd0);
    end
    fetch(32'd12);
    check_val("oor_fault", 32'(fault), 32'd1);
    check_val("oor_ins", ins, NOP);
    fetch(32'd6);
    check_val("mis_fault", 32'(fault), 32'd1);

    // hold freezes the word-1 result for three cycles
    fetch(32'd4);
    repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1, 32'd8, 1'b1);
    check_val("hold_ins", ins, w[1]);
    check_val("hold_valid", 32'(ins_valid), 32'd1);
    fetch(32'd8);
    check_val("rel_ins", ins, w[2]);

    // full array without load_last, then a 17th word that must be dropped
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 32'h0, 1'b0);
    check_val("full_count", 32'(words_loaded), 32'(DEPTH));
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0);
    check_val("full_17", 32'(words_loaded), 32'(DEPTH));
    fetch(32'h40);
    check_val("alias_fault", 32'(fault), 32'd1);
    fetch(32'h3C);
    check_val("last_word", ins, 32'hA000_000F);

    // reset asserted in the middle of the second of four writes
    do_reset();
    step(1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0, 1'b0);
    load_valid = 1'b1; load_data = 32'h2222_2222;
    #2;
    do_reset();
    step(1'b1, 32'h3333_3333, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h4444_4444, 1'b1, 1'b0, 32'h0, 1'b0);
    fetch(32'd4);
    check_val("reload_ins", ins, 32'h4444_4444);

    // randomized rounds
    for (int r = 0; r < 8; r++) begin
      int  n;
      bit  use_last;
      int  i;
      do_reset();
      n = $urandom_range(1, DEPTH);
      use_last = (n < DEPTH) ? 1'b1 : bit'($urandom_range(0, 1));
      i = 0;
      while (i < n) begin
        if ($urandom_range(0, 3) == 0) begin
          step(1'b0, $urandom, 1'b0, bit'($urandom_range(0, 1)), rand_pc(), bit'($urandom_range(0, 1)));
        end else begin
          step(1'b1, $urandom, use_last && (i == n - 1), bit'($urandom_range(0, 1)), rand_pc(),
               bit'($urandom_range(0, 1)));
          i++;
        end
      end
      step(1'b1, $urandom, 1'b1, 1'b0, 32'h0, 1'b0);
      for (int k = 0; k < 40; k++)
        step(bit'($urandom_range(0, 1)), $urandom, 1'b0, $urandom_range(0, 3) != 0, rand_pc(),
             $urandom_range(0, 4) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
